// File: rtl/hex_keypad_entry_if.sv
// Keypad matrix and entry-word signals of hex_keypad_entry.
// The master drives the columns and entry clear; the keypad scanner is the slave.
interface hex_keypad_entry_if;
    logic [3:0]  COL;
    logic        entry_clr;
    logic [3:0]  ROW;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] entry;

    modport master (
        output COL,
        output entry_clr,
        input  ROW,
        input  key_valid,
        input  key_code,
        input  entry
    );

    modport slave (
        input  COL,
        input  entry_clr,
        output ROW,
        output key_valid,
        output key_code,
        output entry
    );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 active-low hex keypad scanner with debounce and a 32-bit digit entry shift register.
// Define KEY_REPEAT_EN to add auto-repeat while a key stays held.
module hex_keypad_entry #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned REPEAT_DLY   = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic               clk,
    input  logic               clr,
    hex_keypad_entry_if.slave  kp
);

    localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
    localparam int unsigned MATCH_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("hex_keypad_entry: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         col_meta_q, col_sync_q;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         row_idx_q, row_idx_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [3:0]         pat_q, pat_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic [31:0]        entry_q;
    logic               tick;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             armed_q, armed_d;
`endif

    function automatic logic single_low(input logic [3:0] s);
        return (s == 4'b1110) || (s == 4'b1101) || (s == 4'b1011) || (s == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] s);
        logic [1:0] idx;
        case (s)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // One row sample per scan period, taken on the last count of the divider.
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        match_d     = match_q;
        pat_d       = pat_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
        armed_d     = armed_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single_low(col_sync_q)) begin
                        pat_d = col_sync_q;
                        if (DEBOUNCE_CNT == 1) begin
                            key_valid_d = 1'b1;
                            key_code_d  = {row_idx_q, low_index(col_sync_q)};
                            match_d     = '0;
                            state_d     = HELD;
                        end else begin
                            match_d = MATCH_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_sync_q == pat_q) begin
                        if (match_q == MATCH_LAST) begin
                            key_valid_d = 1'b1;
                            key_code_d  = {row_idx_q, low_index(pat_q)};
                            match_d     = '0;
                            state_d     = HELD;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d   = '0;
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    // Release needs the same run of clean samples as a press.
                    if (col_sync_q == 4'b1111) begin
                        if (match_q == MATCH_LAST) begin
                            match_d   = '0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
`ifdef KEY_REPEAT_EN
                        if (col_sync_q == pat_q) begin
                            if (armed_q ? (rep_q == RATE_LAST) : (rep_q == DLY_LAST)) begin
                                key_valid_d = 1'b1;
                                rep_d       = '0;
                                armed_d     = 1'b1;
                            end else begin
                                rep_d = rep_q + REP_W'(1);
                            end
                        end
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end
`ifdef KEY_REPEAT_EN
        if (state_d == HELD && state_q != HELD) begin
            rep_d   = '0;
            armed_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            div_q       <= '0;
            row_idx_q   <= '0;
            state_q     <= SCAN;
            match_q     <= '0;
            pat_q       <= '1;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            entry_q     <= '0;
        end else begin
            col_meta_q  <= kp.COL;
            col_sync_q  <= col_meta_q;
            div_q       <= tick ? '0 : div_q + DIV_W'(1);
            row_idx_q   <= row_idx_d;
            state_q     <= state_d;
            match_q     <= match_d;
            pat_q       <= pat_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            // Clear has priority over a coincident digit shift.
            if (kp.entry_clr) begin
                entry_q <= '0;
            end else if (key_valid_d) begin
                entry_q <= {entry_q[27:0], key_code_d};
            end
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            armed_q <= armed_d;
        end
    end
`endif

    assign kp.ROW       = ~(4'b0001 << row_idx_q);
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.entry     = entry_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry: a keypad matrix model drives COL from ROW,
// expected key pulses are queued at press time and compared against captured pulses.
module tb_hex_keypad_entry;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] entry;
    } pulse_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic key_down = 1'b0;
    logic multi = 1'b0;
    logic [3:0] key_sel = 4'h0;
    logic [3:0] col_drv;
    logic [31:0] exp_entry = 32'h0;
    int total = 0;
    int bad = 0;
    pulse_t exp_q[$];
    pulse_t obs_q[$];

    hex_keypad_entry_if kp ();

    hex_keypad_entry #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (2),
        .REPEAT_DLY   (3),
        .REPEAT_RATE  (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low only while its row is driven low.
    always_comb begin
        col_drv = 4'hF;
        if (key_down && kp.ROW[key_sel[3:2]] == 1'b0) col_drv[key_sel[1:0]] = 1'b0;
        if (multi && kp.ROW == 4'b1011) col_drv = 4'b1100;
    end
    assign kp.COL = col_drv;

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) obs_q.push_back({kp.key_code, kp.entry});
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic expect_pulse(input logic [3:0] code, input logic cleared);
        exp_entry = cleared ? 32'h0 : {exp_entry[27:0], code};
        exp_q.push_back({code, exp_entry});
    endtask

    // Returns at the first falling edge after the given row becomes active.
    task automatic align_row(input logic [1:0] r);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << r);
        n = 0;
        while (kp.ROW === want && n < 64) begin @(negedge clk); n++; end
        while (kp.ROW !== want && n < 64) begin @(negedge clk); n++; end
        total++;
        if (kp.ROW !== want) begin
            $display("FAIL row_align ROW=%b want=%b", kp.ROW, want);
            bad++;
        end
    endtask

    task automatic press_key(input logic [3:0] code, input int hold, input logic with_clr);
`ifdef KEY_REPEAT_EN
        int held_n;
`endif
        align_row(code[3:2]);
        key_sel   = code;
        key_down  = 1'b1;
        kp.entry_clr = with_clr;
        expect_pulse(code, with_clr);
`ifdef KEY_REPEAT_EN
        held_n = (hold + 2) / 4 - 2;
        for (int s = 1; s <= held_n; s++) begin
            if (s == 3 || (s > 3 && (s - 3) % 2 == 0)) expect_pulse(code, with_clr);
        end
`endif
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (24) @(negedge clk);
        kp.entry_clr = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] w;
        kp.entry_clr = 1'b0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (kp.ROW !== 4'b1110) begin $display("FAIL reset_row got=%b want=1110", kp.ROW); bad++; end
        total++; if (kp.key_valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", kp.key_valid); bad++; end
        total++; if (kp.key_code !== 4'h0) begin $display("FAIL reset_code got=%h want=0", kp.key_code); bad++; end
        total++; if (kp.entry !== 32'h0) begin $display("FAIL reset_entry got=%h want=0", kp.entry); bad++; end
        @(negedge clk);
        clr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            w = ~(4'b0001 << (k % 4));
            total++;
            if (kp.ROW !== w) begin $display("FAIL rotate_%0d got=%b want=%b", k, kp.ROW, w); bad++; end
        end
        @(negedge clk);
    endtask

    task automatic test_press;
        pulse_t e, o;
        press_key(4'h9, 40, 1'b0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL press_count got=%0d want=%0d", obs_q.size(), exp_q.size()); bad++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.code !== e.code) begin $display("FAIL press_code got=%h want=%h", o.code, e.code); bad++; end
            total++; if (o.entry !== e.entry) begin $display("FAIL press_entry got=%h want=%h", o.entry, e.entry); bad++; end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bounce;
        int n;
        align_row(2'd2);
        key_sel  = 4'h9;
        key_down = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (kp.ROW !== 4'b1011) begin $display("FAIL bounce_hold got=%b want=1011", kp.ROW); bad++; end
        key_down = 1'b0;
        n = 0;
        while (kp.ROW !== 4'b0111 && n < 12) begin @(negedge clk); n++; end
        total++;
        if (kp.ROW !== 4'b0111) begin $display("FAIL bounce_resume got=%b want=0111", kp.ROW); bad++; end
        repeat (20) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin $display("FAIL bounce_count got=%0d want=0", obs_q.size()); bad++; end
        obs_q.delete();
    endtask

    task automatic test_sequence;
        pulse_t e, o;
        for (int k = 1; k <= 9; k++) press_key(4'(k), 12, 1'b0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL seq_count got=%0d want=%0d", obs_q.size(), exp_q.size()); bad++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.code !== e.code) begin $display("FAIL seq_code got=%h want=%h", o.code, e.code); bad++; end
            total++; if (o.entry !== e.entry) begin $display("FAIL seq_entry got=%h want=%h", o.entry, e.entry); bad++; end
        end
        exp_q.delete(); obs_q.delete();
        total++;
        if (kp.entry !== 32'h23456789) begin $display("FAIL seq_final got=%h want=23456789", kp.entry); bad++; end

        press_key(4'hB, 12, 1'b1);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL clr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); bad++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.code !== e.code) begin $display("FAIL clr_code got=%h want=%h", o.code, e.code); bad++; end
            total++; if (o.entry !== e.entry) begin $display("FAIL clr_entry got=%h want=%h", o.entry, e.entry); bad++; end
        end
        exp_q.delete(); obs_q.delete();
        total++;
        if (kp.entry !== 32'h0) begin $display("FAIL clr_final got=%h want=0", kp.entry); bad++; end
    endtask

    task automatic test_two_cols_and_abort;
        pulse_t e, o;
        logic seen;
        seen  = 1'b0;
        multi = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kp.ROW === 4'b0111) seen = 1'b1;
        end
        multi = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (seen !== 1'b1) begin $display("FAIL multi_rotate got=%b want=1", seen); bad++; end
        total++;
        if (obs_q.size() != 0) begin $display("FAIL multi_count got=%0d want=0", obs_q.size()); bad++; end
        obs_q.delete();

        press_key(4'h7, 12, 1'b0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL key7_count got=%0d want=%0d", obs_q.size(), exp_q.size()); bad++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.code !== e.code) begin $display("FAIL key7_code got=%h want=%h", o.code, e.code); bad++; end
            total++; if (o.entry !== e.entry) begin $display("FAIL key7_entry got=%h want=%h", o.entry, e.entry); bad++; end
        end
        exp_q.delete(); obs_q.delete();

        align_row(2'd1);
        key_sel  = 4'h5;
        key_down = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (kp.ROW !== 4'b1101) begin $display("FAIL abort_hold got=%b want=1101", kp.ROW); bad++; end
        clr      = 1'b1;
        key_down = 1'b0;
        @(posedge clk);
        #1;
        total++; if (kp.ROW !== 4'b1110) begin $display("FAIL abort_row got=%b want=1110", kp.ROW); bad++; end
        total++; if (kp.key_valid !== 1'b0) begin $display("FAIL abort_valid got=%b want=0", kp.key_valid); bad++; end
        total++; if (kp.key_code !== 4'h0) begin $display("FAIL abort_code got=%h want=0", kp.key_code); bad++; end
        total++; if (kp.entry !== 32'h0) begin $display("FAIL abort_entry got=%h want=0", kp.entry); bad++; end
        @(negedge clk);
        clr = 1'b0;
        exp_entry = 32'h0;
        repeat (30) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin $display("FAIL abort_count got=%0d want=0", obs_q.size()); bad++; end
        obs_q.delete();
    endtask

    task automatic test_held_long;
        pulse_t e, o;
        press_key(4'hA, 60, 1'b0);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            $display("FAIL held_count got=%0d want=%0d", obs_q.size(), exp_q.size()); bad++;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o.code !== e.code) begin $display("FAIL held_code got=%h want=%h", o.code, e.code); bad++; end
            total++; if (o.entry !== e.entry) begin $display("FAIL held_entry got=%h want=%h", o.entry, e.entry); bad++; end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        kp.entry_clr = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_sequence();
        test_two_cols_and_abort();
        test_held_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
